// File: rtl/tbus_arbiter_if.sv
// Request/grant/enable bundle between requesting logic, tbus_arbiter and the tri-state driver bank.
// master: the arbiter side; slave: requesters and driver cells.
interface tbus_arbiter_if #(
    parameter int unsigned N = 4
) ();
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] en;
    logic [N-1:0] en_bar;
    logic         busy;
    logic         tout;

    modport master (
        input  req,
        output gnt,
        output en,
        output en_bar,
        output busy,
        output tout
    );

    modport slave (
        output req,
        input  gnt,
        input  en,
        input  en_bar,
        input  busy,
        input  tout
    );
endinterface

// File: rtl/tbus_arbiter.sv
// Round-robin arbiter and EN/EN_BAR sequencer for one tri-state bus net, with a dead gap between
// owners. Define TBUS_ARBITER_TIMEOUT_EN to end any tenure after HOLD_MAX cycles and pulse TOUT.
module tbus_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned DEAD     = 1,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    tbus_arbiter_if.master bus_io
);
    localparam int unsigned PtrW = $clog2(N);
    localparam bit ParamsOk = (N >= 2) && (N <= 8) && (DEAD >= 1) && (DEAD <= 15) &&
                              (HOLD_MAX >= 2) && (HOLD_MAX <= 255);

    if (!ParamsOk) begin : g_bad_params
        $error("tbus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDead
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [3:0]      dead_q, dead_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    en_q, en_d;
    logic [N-1:0]    en_bar_q, en_bar_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    req;
    logic            win_valid;
    logic [PtrW-1:0] win_idx;
    logic [N-1:0]    win_onehot;
    logic [PtrW:0]   rr_idx;
    logic            do_grant;
    logic            do_release;

`ifdef TBUS_ARBITER_TIMEOUT_EN
    logic [7:0]      hold_q, hold_d;
    logic            tout_q, tout_d;
`endif

    assign req = bus_io.req;

    // Search starts just after the last owner and wraps, so the last owner is lowest priority.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_q;
        rr_idx    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            rr_idx = {1'b0, ptr_q} + (PtrW+1)'(i);
            if (rr_idx >= (PtrW+1)'(N)) begin
                rr_idx = rr_idx - (PtrW+1)'(N);
            end
            if (!win_valid && req[rr_idx[PtrW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = rr_idx[PtrW-1:0];
            end
        end
    end

    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dead_d     = dead_q;
        gnt_d      = gnt_q;
        en_d       = en_q;
        do_grant   = 1'b0;
        do_release = 1'b0;
`ifdef TBUS_ARBITER_TIMEOUT_EN
        hold_d     = hold_q;
        tout_d     = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                do_grant = win_valid;
            end
            StDrive: begin
                // The pointer doubles as the owner index for the whole tenure.
                if (!req[ptr_q]) begin
                    do_release = 1'b1;
`ifdef TBUS_ARBITER_TIMEOUT_EN
                end else if (hold_q == 8'(HOLD_MAX)) begin
                    do_release = 1'b1;
                    tout_d     = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            StDead: begin
                if (dead_q != 4'd0) begin
                    dead_d = dead_q - 4'd1;
                end else if (win_valid) begin
                    do_grant = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_grant) begin
            state_d = StDrive;
            ptr_d   = win_idx;
            gnt_d   = win_onehot;
            en_d    = win_onehot;
`ifdef TBUS_ARBITER_TIMEOUT_EN
            hold_d  = 8'd1;
`endif
        end

        if (do_release) begin
            state_d = StDead;
            gnt_d   = '0;
            en_d    = '0;
            dead_d  = 4'(DEAD - 1);
`ifdef TBUS_ARBITER_TIMEOUT_EN
            hold_d  = 8'd0;
`endif
        end

        en_bar_d = ~en_d;
        busy_d   = (state_d != StIdle);
    end

    // Async reset drops every enable at once so the bus goes high-Z without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ptr_q    <= PtrW'(N - 1);
            dead_q   <= 4'd0;
            gnt_q    <= '0;
            en_q     <= '0;
            en_bar_q <= '1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dead_q   <= dead_d;
            gnt_q    <= gnt_d;
            en_q     <= en_d;
            en_bar_q <= en_bar_d;
            busy_q   <= busy_d;
        end
    end

`ifdef TBUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= 8'd0;
            tout_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tout_q <= tout_d;
        end
    end

    assign bus_io.tout = tout_q;
`else
    assign bus_io.tout = 1'b0;
`endif

    assign bus_io.gnt    = gnt_q;
    assign bus_io.en     = en_q;
    assign bus_io.en_bar = en_bar_q;
    assign bus_io.busy   = busy_q;
endmodule
